// File: rtl/reg_dump_reader.sv
// Debug dump engine: walks register-file addresses 0..NUM_REGS-1 and streams {addr, data} words out over valid/ready.
// Optional trailing XOR checksum word is enabled by defining CHECKSUM_EN.
module reg_dump_reader #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] ReadReg,
    input  logic [DATA_W-1:0] ReadData,
    output logic              DumpValid,
    input  logic              DumpReady,
    output logic [ADDR_W-1:0] DumpAddr,
    output logic [DATA_W-1:0] DumpData,
    output logic              DumpLast,
    output logic              DumpSum
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
`ifdef CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   read_reg_q, read_reg_d;
    logic                dump_valid_q, dump_valid_d;
    logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0]   dump_data_q, dump_data_d;
    logic                dump_last_q, dump_last_d;
`ifdef CHECKSUM_EN
    logic                dump_sum_q, dump_sum_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        read_reg_d   = read_reg_q;
        dump_valid_d = dump_valid_q;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        dump_last_d  = dump_last_q;
`ifdef CHECKSUM_EN
        dump_sum_d   = dump_sum_q;
        csum_d       = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef CHECKSUM_EN
                csum_d = '0;
`endif
                if (Start) begin
                    read_reg_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                dump_data_d  = ReadData;
                dump_addr_d  = read_reg_q;
                dump_valid_d = 1'b1;
`ifdef CHECKSUM_EN
                dump_last_d  = 1'b0;
                csum_d       = csum_q ^ ReadData;
`else
                dump_last_d  = (read_reg_q == LAST_ADDR);
`endif
                state_d      = S_SEND;
            end
            S_SEND: begin
                // Outputs hold by default until the sink takes the word
                if (dump_valid_q && DumpReady) begin
                    dump_valid_d = 1'b0;
                    dump_last_d  = 1'b0;
`ifdef CHECKSUM_EN
                    dump_sum_d   = 1'b0;
                    if (dump_sum_q) begin
                        state_d = S_DONE;
                    end else if (read_reg_q < LAST_ADDR) begin
                        read_reg_d = read_reg_q + ADDR_W'(1);
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_CSUM;
                    end
`else
                    if (read_reg_q < LAST_ADDR) begin
                        read_reg_d = read_reg_q + ADDR_W'(1);
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
`ifdef CHECKSUM_EN
            S_CSUM: begin
                dump_data_d  = csum_q;
                dump_addr_d  = '0;
                dump_sum_d   = 1'b1;
                dump_last_d  = 1'b1;
                dump_valid_d = 1'b1;
                state_d      = S_SEND;
            end
`endif
            S_DONE: begin
                read_reg_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            read_reg_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_last_q  <= 1'b0;
`ifdef CHECKSUM_EN
            dump_sum_q   <= 1'b0;
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            read_reg_q   <= read_reg_d;
            dump_valid_q <= dump_valid_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
            dump_last_q  <= dump_last_d;
`ifdef CHECKSUM_EN
            dump_sum_q   <= dump_sum_d;
            csum_q       <= csum_d;
`endif
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign ReadReg   = read_reg_q;
    assign DumpValid = dump_valid_q;
    assign DumpAddr  = dump_addr_q;
    assign DumpData  = dump_data_q;
    assign DumpLast  = dump_last_q;
`ifdef CHECKSUM_EN
    assign DumpSum   = dump_sum_q;
`else
    assign DumpSum   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: table-driven dump scenarios checked against a word-stream model built from the register file.
module tb_reg_dump_reader;

    localparam int N = 32;
`ifdef CHECKSUM_EN
    localparam int HAS_CSUM = 1;
`else
    localparam int HAS_CSUM = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, dump_ready, start4, ready4;
    logic        busy, done, dump_valid, dump_last, dump_sum;
    logic [4:0]  read_reg, dump_addr;
    logic [31:0] read_data, dump_data;
    logic        busy4, done4, valid4, last4, sum4;
    logic [4:0]  read_reg4, addr4;
    logic [31:0] read_data4, data4;
    logic [31:0] rf [N];

    always #5 clk = ~clk;

    assign read_data  = rf[read_reg];
    assign read_data4 = rf[read_reg4];

    reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .CLK(clk), .RST(rst), .Start(start), .Busy(busy), .Done(done),
        .ReadReg(read_reg), .ReadData(read_data), .DumpValid(dump_valid),
        .DumpReady(dump_ready), .DumpAddr(dump_addr), .DumpData(dump_data),
        .DumpLast(dump_last), .DumpSum(dump_sum)
    );

    reg_dump_reader #(.NUM_REGS(4), .ADDR_W(5), .DATA_W(32)) dut4 (
        .CLK(clk), .RST(rst), .Start(start4), .Busy(busy4), .Done(done4),
        .ReadReg(read_reg4), .ReadData(read_data4), .DumpValid(valid4),
        .DumpReady(ready4), .DumpAddr(addr4), .DumpData(data4),
        .DumpLast(last4), .DumpSum(sum4)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
        logic        sum;
    } word_t;

    typedef struct {
        int          fill;         // 0: i*0x11, 1: random, 2: r1/r2 pattern
        int          ready_pct;
        int          stall_addr;   // -1: none
        int          stall_len;
        int          restart_addr; // -1: none
        int          exp_dur;      // -1: not checked
        int          chk_last;
        logic [31:0] exp_last;
    } vec_t;

    word_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       rf[i] = 32'(i) * 32'h11;
                1:       rf[i] = $urandom;
                default: rf[i] = 32'h0;
            endcase
        end
        if (mode == 2) begin
            rf[1] = 32'hA5A5_A5A5;
            rf[2] = 32'h0F0F_0F0F;
        end
    endtask

    // Expected output stream: one word per register, then an XOR word if the checksum is built in
    task automatic build_expected(input int nregs);
        logic [31:0] x;
        word_t       w;
        x = 32'h0;
        exp_q.delete();
        for (int i = 0; i < nregs; i++) begin
            w.addr = 5'(i);
            w.data = rf[i];
            w.last = (i == nregs - 1) && (HAS_CSUM == 0);
            w.sum  = 1'b0;
            exp_q.push_back(w);
            x = x ^ rf[i];
        end
        if (HAS_CSUM != 0) begin
            w.addr = 5'd0;
            w.data = x;
            w.last = 1'b1;
            w.sum  = 1'b1;
            exp_q.push_back(w);
        end
    endtask

    task automatic run_dump(input vec_t v);
        int          words, dones, dur, stall_left, max_rr, n_exp;
        bit          stalled_prev, stall_used, restarted;
        logic        pl, ps;
        logic [4:0]  pa;
        logic [31:0] pd, last_data;
        word_t       w;
        words = 0; dones = 0; dur = -1; stall_left = 0; max_rr = 0;
        stalled_prev = 0; stall_used = 0; restarted = 0;
        pl = 0; ps = 0; pa = '0; pd = '0; last_data = '0;
        fill(v.fill);
        build_expected(N);
        n_exp = exp_q.size();
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (v.restart_addr >= 0 && !restarted && dump_valid && dump_addr == 5'(v.restart_addr)) begin
                start     = 1'b1;
                restarted = 1;
            end
            if (32'(read_reg) > max_rr) max_rr = 32'(read_reg);
            if (cyc == 1) begin
                check("busy_after_start", 32'(busy), 32'd1);
                check("no_valid_in_fetch", 32'(dump_valid), 32'd0);
            end
            if (cyc == 2) check("first_valid_latency", 32'(dump_valid), 32'd1);
            if (done) begin
                dones++;
                if (dur < 0) dur = cyc;
            end
            if (stalled_prev) begin
                check("hold_valid", 32'(dump_valid), 32'd1);
                check("hold_addr", 32'(dump_addr), 32'(pa));
                check("hold_data", dump_data, pd);
                check("hold_last", 32'(dump_last), 32'(pl));
                check("hold_sum", 32'(dump_sum), 32'(ps));
            end
            if (!stall_used && v.stall_addr >= 0 && dump_valid && dump_addr == 5'(v.stall_addr)) begin
                stall_used = 1;
                stall_left = v.stall_len;
            end
            if (stall_left > 0) begin
                dump_ready = 1'b0;
                stall_left--;
            end else begin
                dump_ready = (int'($urandom_range(99)) < v.ready_pct);
            end
            if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'd1, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("word_addr", 32'(dump_addr), 32'(w.addr));
                    check("word_data", dump_data, w.data);
                    check("word_last", 32'(dump_last), 32'(w.last));
                    check("word_sum", 32'(dump_sum), 32'(w.sum));
                end
                words++;
                last_data = dump_data;
            end
            stalled_prev = dump_valid && !dump_ready;
            pa = dump_addr; pd = dump_data; pl = dump_last; ps = dump_sum;
            if (dur >= 0 && cyc >= dur + 4) break;
        end
        start = 1'b0;
        dump_ready = 1'b0;
        check("word_count", 32'(words), 32'(n_exp));
        check("done_pulses", 32'(dones), 32'd1);
        check("max_read_reg", 32'(max_rr), 32'(N - 1));
        check("idle_after_done", 32'(busy), 32'd0);
        check("read_reg_back_to_0", 32'(read_reg), 32'd0);
        if (v.exp_dur > 0) check("dump_duration", 32'(dur), 32'(v.exp_dur));
        if (v.chk_last != 0) check("final_word_data", last_data, v.exp_last);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl [7];
        word_t w;
        int    found, dones, words, max_rr;

        tbl[0] = '{0, 100, -1, 0, -1, 65 + 2*HAS_CSUM, (HAS_CSUM == 0) ? 1 : 0, 32'h0000_020F};
        tbl[1] = '{0, 100,  7, 5, -1, 70 + 2*HAS_CSUM, 0, 32'h0};
        tbl[2] = '{0, 100, -1, 0, 10, 65 + 2*HAS_CSUM, 0, 32'h0};
        tbl[3] = '{2, 100, -1, 0, -1, 65 + 2*HAS_CSUM, 1, (HAS_CSUM != 0) ? 32'hAAAA_AAAA : 32'h0};
        tbl[4] = '{1,  50, -1, 0, -1, -1, 0, 32'h0};
        tbl[5] = '{1,  30,  3, 2, 20, -1, 0, 32'h0};
        tbl[6] = '{1,  80, 31, 3, -1, -1, 0, 32'h0};

        rst = 1'b1; start = 1'b0; dump_ready = 1'b0; start4 = 1'b0; ready4 = 1'b0;
        fill(0);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_last", 32'(dump_last), 32'd0);
        check("rst_sum", 32'(dump_sum), 32'd0);
        check("rst_readreg", 32'(read_reg), 32'd0);
        check("rst_addr", 32'(dump_addr), 32'd0);
        check("rst_data", dump_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 7; t++) run_dump(tbl[t]);

        // Reset while a word for address 12 is waiting in SEND
        fill(0);
        dump_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (dump_valid && dump_addr == 5'd12) begin
                found = 1;
                break;
            end
        end
        dump_ready = 1'b0;
        check("reach_addr12", 32'(found), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", 32'(dump_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_readreg", 32'(read_reg), 32'd0);
        check("midrst_last", 32'(dump_last), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        run_dump(tbl[0]);

        // Four-register instance
        fill(1);
        build_expected(4);
        dones = 0; words = 0; max_rr = 0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        ready4 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (32'(read_reg4) > max_rr) max_rr = 32'(read_reg4);
            if (done4) dones++;
            if (valid4 && ready4) begin
                words++;
                if (exp_q.size() == 0) begin
                    check("n4_extra_word", 32'd1, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("n4_addr", 32'(addr4), 32'(w.addr));
                    check("n4_data", data4, w.data);
                    check("n4_last", 32'(last4), 32'(w.last));
                    check("n4_sum", 32'(sum4), 32'(w.sum));
                end
            end
        end
        ready4 = 1'b0;
        check("n4_words", 32'(words), 32'(4 + HAS_CSUM));
        check("n4_max_read_reg", 32'(max_rr), 32'd3);
        check("n4_done_pulses", 32'(dones), 32'd1);
        check("n4_idle", 32'(busy4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
